uart_word_assembler: RTL and testbench
======================================

// Module: uart_word_assembler
// PURPOSE
//   Consumes the byte stream from the UART receiver (data + done tick) and packs
//   NBYTES consecutive bytes, little-endian, into one word for the debugger.
//   Presents the word with a valid/ready handshake, flags bytes lost while a word
//   is held, and can optionally drop stale partial words after a line-idle timeout.
// PARAMETERS
//   DBIT          8     bits per received byte (matches receiver DBIT)
//   NBYTES        4     bytes per output word (>=2)
//   TIMEOUT_TICKS 2560  i_s_tick count before a partial word is discarded (used only with RX_TIMEOUT_EN)
// PORTS
//   i_clk           in   1              system clock, rising edge
//   i_reset_n       in   1              asynchronous active-low reset
//   i_rx_done_tick  in   1              one-cycle strobe: i_rx_data is a new byte
//   i_rx_data       in   DBIT           received byte, sampled only when i_rx_done_tick=1
//   i_s_tick        in   1              baud-rate generator oversampling tick (timeout base)
//   i_flush         in   1              synchronous clear of partial word, held word and overflow
//   i_ready         in   1              consumer accepts o_word this cycle
//   o_word          out  DBIT*NBYTES    assembled word; byte k at bits [k*DBIT +: DBIT]
//   o_valid         out  1              o_word holds a complete word
//   o_byte_cnt      out  clog2(NBYTES)+1  bytes collected toward the current word
//   o_overflow      out  1              sticky: a byte arrived while a word was held and not accepted
//   o_timeout       out  1              one-cycle pulse: partial word discarded by timeout
// BEHAVIOUR
//   - Reset (async, i_reset_n=0): state COLLECT; o_word=0, o_valid=0, o_byte_cnt=0,
//     o_overflow=0, o_timeout=0, timeout counter=0. Reset mid-word discards it.
//   - States: COLLECT (gathering bytes), HOLD (full word presented, o_valid=1).
//   - COLLECT + i_rx_done_tick: write byte into slot o_byte_cnt; cnt+1. On the byte
//     with cnt==NBYTES-1: word registered, cnt->0, state->HOLD; o_valid=1 on the
//     next cycle (latency 1 clock from the last done tick).
//   - HOLD: o_word stable. o_valid & i_ready -> COLLECT, o_valid=0 next cycle.
//   - HOLD + i_rx_done_tick + i_ready same cycle: word accepted AND the byte is
//     stored as byte 0 of the next word (cnt=1); no overflow.
//   - HOLD + i_rx_done_tick + !i_ready: byte dropped, o_overflow<=1 (sticky), held
//     word unchanged.
//   - i_flush has priority over all events in its cycle: cnt=0, o_valid=0,
//     o_overflow=0, timeout counter=0, state->COLLECT; a concurrent byte is dropped
//     without setting overflow. o_word contents after flush are don't-care.
//   - Unwritten slots of a partial word keep prior contents; only o_valid qualifies o_word.
//   - o_byte_cnt never exceeds NBYTES-1 while in COLLECT; 0 while in HOLD.
// CONFIGURATION
//   RX_TIMEOUT_EN defined:
//     - In COLLECT with cnt>0, counter increments on each i_s_tick; cleared on every
//       accepted byte, on flush, and when cnt==0.
//     - Counter reaching TIMEOUT_TICKS-1 on an i_s_tick: cnt->0, counter->0,
//       o_timeout=1 for exactly one cycle. If a byte arrives that same cycle the byte
//       wins: it is accepted, counter clears, no timeout.
//     - Counter frozen in HOLD.
//   RX_TIMEOUT_EN undefined: no counter logic; o_timeout tied 0; partial words
//     persist indefinitely; TIMEOUT_TICKS and i_s_tick unused.
// TESTING
//   1. Bytes 0x11,0x22,0x33,0x44 with i_ready=1 -> o_word=0x44332211, o_valid high
//      exactly 1 cycle, starting 1 clock after 4th tick.
//   2. Full word held, i_ready=0, byte 0x55 arrives -> o_overflow=1, o_word unchanged;
//      then i_ready=1 -> o_valid drops, o_overflow stays 1 until i_flush.
//   3. Held word, byte 0xAA with i_ready=1 same cycle -> word accepted, o_byte_cnt=1;
//      3 more bytes 0xBB,0xCC,0xDD -> o_word=0xDDCCBBAA, no overflow.
//   4. Two bytes then i_flush (with concurrent byte) -> o_byte_cnt=0, o_valid=0,
//      o_overflow=0; next 4 bytes form a clean word.
//   5. RX_TIMEOUT_EN, TIMEOUT_TICKS=32: one byte then 32 i_s_ticks idle -> o_timeout
//      1-cycle pulse, o_byte_cnt=0; byte on the 32nd tick cycle -> no timeout, cnt=2.
//   6. Assert i_reset_n=0 after 3 bytes -> all outputs 0 immediately (async); 4 new
//      bytes after release yield one complete word.

Source files
------------

// File: rtl/uart_word_assembler.sv
// uart_word_assembler: packs NBYTES received UART bytes (little-endian) into one word with a valid/ready handshake
// Ports: i_clk, i_reset_n (async active-low), i_rx_done_tick/i_rx_data (byte strobe + byte),
//   i_s_tick (timeout base), i_flush (clear partial/held word and overflow), i_ready (consumer accept),
//   o_word, o_valid, o_byte_cnt, o_overflow (sticky byte loss), o_timeout (partial word discarded pulse).
// Optional RX_TIMEOUT_EN: discard a stale partial word after TIMEOUT_TICKS idle i_s_ticks.
module uart_word_assembler #(
  parameter int DBIT          = 8,
  parameter int NBYTES        = 4,
  parameter int TIMEOUT_TICKS = 2560
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_rx_done_tick,
  input  logic [DBIT-1:0]            i_rx_data,
  input  logic                       i_s_tick,
  input  logic                       i_flush,
  input  logic                       i_ready,
  output logic [DBIT*NBYTES-1:0]     o_word,
  output logic                       o_valid,
  output logic [$clog2(NBYTES):0]    o_byte_cnt,
  output logic                       o_overflow,
  output logic                       o_timeout
);
  localparam int CW = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
  typedef enum logic {COLLECT, HOLD} state_e;
  state_e state_q, state_d;
  logic [DBIT*NBYTES-1:0] word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_TICKS - 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic tout_q, tout_d;
  assign o_timeout = tout_q;
`else
  logic unused_s_tick;
  assign unused_s_tick = i_s_tick ^ (TIMEOUT_TICKS == 0);
  assign o_timeout = 1'b0;
`endif
  assign o_word     = word_q;
  assign o_valid    = state_q == HOLD;
  assign o_byte_cnt = cnt_q;
  assign o_overflow = ovf_q;
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef RX_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    tout_d  = 1'b0;
`endif
    if (i_flush) begin
      state_d = COLLECT;
      cnt_d   = '0;
      ovf_d   = 1'b0;
`ifdef RX_TIMEOUT_EN
      tcnt_d  = '0;
`endif
    end else if (state_q == HOLD) begin
      if (i_ready) begin
        state_d = COLLECT;
        // A byte arriving with the accept starts the next word in slot 0
        if (i_rx_done_tick) begin
          word_d[DBIT-1:0] = i_rx_data;
          cnt_d = CW'(1);
`ifdef RX_TIMEOUT_EN
          tcnt_d = '0;
`endif
        end
      end else if (i_rx_done_tick) begin
        ovf_d = 1'b1;
      end
    end else if (i_rx_done_tick) begin
      word_d[int'(cnt_q)*DBIT +: DBIT] = i_rx_data;
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      state_d = (cnt_q == LAST) ? HOLD : COLLECT;
`ifdef RX_TIMEOUT_EN
      tcnt_d  = '0;
    end else if (cnt_q == '0) begin
      tcnt_d = '0;
    end else if (i_s_tick) begin
      if (tcnt_q == TLAST) begin
        cnt_d  = '0;
        tcnt_d = '0;
        tout_d = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
`endif
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= COLLECT;
      word_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef RX_TIMEOUT_EN
      tcnt_q  <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
`ifdef RX_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      tout_q  <= tout_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_word_assembler.sv
// tb_uart_word_assembler: directed bench with a queue-based reference model of the word assembler
module tb_uart_word_assembler;
  localparam int NB = 4;
  localparam int T  = 32;
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  logic i_rx_done_tick = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic i_s_tick = 1'b0;
  logic i_flush = 1'b0;
  logic i_ready = 1'b0;
  logic [31:0] o_word;
  logic o_valid;
  logic [2:0] o_byte_cnt;
  logic o_overflow;
  logic o_timeout;
  int checks = 0;
  int failures = 0;
  uart_word_assembler #(.DBIT(8), .NBYTES(NB), .TIMEOUT_TICKS(T)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rx_done_tick(i_rx_done_tick),
    .i_rx_data(i_rx_data), .i_s_tick(i_s_tick), .i_flush(i_flush), .i_ready(i_ready),
    .o_word(o_word), .o_valid(o_valid), .o_byte_cnt(o_byte_cnt),
    .o_overflow(o_overflow), .o_timeout(o_timeout));
  always #5 i_clk = ~i_clk;
  // model state: bytes of the partial word, the held word and flags
  logic [7:0] part[$];
  logic [31:0] m_word = '0;
  logic m_valid = 1'b0;
  logic m_ovf = 1'b0;
  logic m_tout = 1'b0;
  int m_tcnt = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge i_clk or negedge i_reset_n);
    if (!i_reset_n) begin
      part.delete();
      m_word = '0;
      m_valid = 1'b0;
      m_ovf = 1'b0;
      m_tout = 1'b0;
      m_tcnt = 0;
    end else begin
      m_tout = 1'b0;
      if (i_flush) begin
        part.delete();
        m_valid = 1'b0;
        m_ovf = 1'b0;
        m_tcnt = 0;
      end else if (m_valid) begin
        if (i_ready) begin
          m_valid = 1'b0;
          if (i_rx_done_tick) begin
            part.push_back(i_rx_data);
            m_tcnt = 0;
          end
        end else if (i_rx_done_tick) begin
          m_ovf = 1'b1;
        end
      end else if (i_rx_done_tick) begin
        part.push_back(i_rx_data);
        m_tcnt = 0;
        if (part.size() == NB) begin
          m_word = '0;
          for (int k = 0; k < NB; k++) m_word = m_word | (32'(part[k]) << (8 * k));
          m_valid = 1'b1;
          part.delete();
        end
      end else begin
`ifdef RX_TIMEOUT_EN
        if (part.size() == 0) m_tcnt = 0;
        else if (i_s_tick) begin
          if (m_tcnt == T - 1) begin
            part.delete();
            m_tcnt = 0;
            m_tout = 1'b1;
          end else m_tcnt++;
        end
`endif
      end
    end
  end
  initial forever begin
    @(negedge i_clk);
    check("valid", 32'(o_valid), 32'(m_valid));
    check("byte_cnt", 32'(o_byte_cnt), part.size());
    check("overflow", 32'(o_overflow), 32'(m_ovf));
    check("timeout", 32'(o_timeout), 32'(m_tout));
    if (m_valid) check("word", o_word, m_word);
  end
  task automatic step(input logic d, input logic [7:0] b, input logic r, input logic f, input logic s);
    @(negedge i_clk);
    #1;
    i_rx_done_tick = d;
    i_rx_data = b;
    i_ready = r;
    i_flush = f;
    i_s_tick = s;
  endtask
  task automatic idle(input logic r);
    step(1'b0, 8'h00, r, 1'b0, 1'b0);
  endtask
  task automatic put(input logic [7:0] b, input logic r);
    step(1'b1, b, r, 1'b0, 1'b0);
  endtask
  initial begin
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_word", o_word, 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_cnt", 32'(o_byte_cnt), 32'h0);
    check("rst_ovf", 32'(o_overflow), 32'h0);
    check("rst_tout", 32'(o_timeout), 32'h0);
    i_reset_n = 1'b1;
    // 1: basic word, ready held high
    put(8'h11, 1'b1); put(8'h22, 1'b1); put(8'h33, 1'b1); put(8'h44, 1'b1);
    idle(1'b1);
    check("t1_valid", 32'(o_valid), 32'h1);
    check("t1_word", o_word, 32'h44332211);
    idle(1'b0);
    check("t1_valid_drop", 32'(o_valid), 32'h0);
    // 2: overflow while held
    put(8'h01, 1'b0); put(8'h02, 1'b0); put(8'h03, 1'b0); put(8'h04, 1'b0);
    put(8'h55, 1'b0);
    idle(1'b0);
    check("t2_ovf", 32'(o_overflow), 32'h1);
    check("t2_word", o_word, 32'h04030201);
    check("t2_valid", 32'(o_valid), 32'h1);
    idle(1'b1);
    idle(1'b0);
    check("t2_valid_drop", 32'(o_valid), 32'h0);
    check("t2_ovf_sticky", 32'(o_overflow), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    check("t2_ovf_flush", 32'(o_overflow), 32'h0);
    // 3: byte accepted in the same cycle as the held word
    put(8'h10, 1'b0); put(8'h20, 1'b0); put(8'h30, 1'b0); put(8'h40, 1'b0);
    put(8'hAA, 1'b1);
    idle(1'b0);
    check("t3_valid_drop", 32'(o_valid), 32'h0);
    check("t3_cnt", 32'(o_byte_cnt), 32'h1);
    put(8'hBB, 1'b0); put(8'hCC, 1'b0); put(8'hDD, 1'b0);
    idle(1'b0);
    check("t3_word", o_word, 32'hDDCCBBAA);
    check("t3_ovf", 32'(o_overflow), 32'h0);
    idle(1'b1);
    // 4: flush mid-word with a concurrent byte
    put(8'h01, 1'b0); put(8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    check("t4_cnt", 32'(o_byte_cnt), 32'h0);
    check("t4_valid", 32'(o_valid), 32'h0);
    check("t4_ovf", 32'(o_overflow), 32'h0);
    put(8'h5A, 1'b0); put(8'h6B, 1'b0); put(8'h7C, 1'b0); put(8'h8D, 1'b0);
    idle(1'b1);
    check("t4_word", o_word, 32'h8D7C6B5A);
    idle(1'b0);
    // 5: idle timeout
`ifdef RX_TIMEOUT_EN
    put(8'h01, 1'b0);
    repeat (T - 1) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check("t5_pre_tout", 32'(o_timeout), 32'h0);
    check("t5_pre_cnt", 32'(o_byte_cnt), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check("t5_tout", 32'(o_timeout), 32'h1);
    check("t5_cnt", 32'(o_byte_cnt), 32'h0);
    idle(1'b0);
    check("t5_tout_pulse", 32'(o_timeout), 32'h0);
    put(8'h01, 1'b0);
    repeat (T - 1) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check("t5_byte_wins_tout", 32'(o_timeout), 32'h0);
    check("t5_byte_wins_cnt", 32'(o_byte_cnt), 32'h2);
`else
    put(8'h01, 1'b0);
    repeat (T + 8) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check("t5_no_tout", 32'(o_timeout), 32'h0);
    check("t5_cnt_kept", 32'(o_byte_cnt), 32'h1);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    // 6: async reset mid-word
    put(8'hE1, 1'b0); put(8'hE2, 1'b0); put(8'hE3, 1'b0);
    idle(1'b0);
    #2 i_reset_n = 1'b0;
    #1;
    check("t6_word", o_word, 32'h0);
    check("t6_cnt", 32'(o_byte_cnt), 32'h0);
    check("t6_valid", 32'(o_valid), 32'h0);
    check("t6_ovf", 32'(o_overflow), 32'h0);
    idle(1'b0);
    i_reset_n = 1'b1;
    put(8'hC1, 1'b0); put(8'hC2, 1'b0); put(8'hC3, 1'b0); put(8'hC4, 1'b0);
    idle(1'b1);
    check("t6_new_valid", 32'(o_valid), 32'h1);
    check("t6_new_word", o_word, 32'hC4C3C2C1);
    idle(1'b0);
    idle(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
